// File: rtl/job_dispatcher_pkg.sv
// Shared types and width constants for the job dispatcher: FSM state encoding,
// descriptor field widths and the largest compressed block the decompressors accept.
package job_dispatcher_pkg;

  localparam int ADDR_W          = 64;
  localparam int CLEN_W          = 35;
  localparam int DLEN_W          = 32;
  localparam int JOB_ID_W        = 16;
  localparam int MAX_BLOCK_BYTES = 65536;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/job_dispatcher.sv
// Loads one descriptor per decompressor slot into the I/O controller, starts the batch
// and tracks it to completion. Optional length screening: define DISPATCH_LEN_CHECK_EN.
module job_dispatcher
  import job_dispatcher_pkg::*;
#(
  parameter int NUM_DECOMPRESSOR = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                desc_valid,
  output logic                desc_ready,
  input  logic [ADDR_W-1:0]   desc_src_addr,
  input  logic [ADDR_W-1:0]   desc_des_addr,
  input  logic [CLEN_W-1:0]   desc_comp_len,
  input  logic [DLEN_W-1:0]   desc_decomp_len,
  input  logic                desc_last,
  output logic                job_valid_o,
  output logic [JOB_ID_W-1:0] job_id_o,
  output logic [ADDR_W-1:0]   src_addr_o,
  output logic [ADDR_W-1:0]   des_addr_o,
  output logic [CLEN_W-1:0]   comp_len_o,
  output logic [DLEN_W-1:0]   decomp_len_o,
  output logic                start_o,
  input  logic                io_idle,
  input  logic                io_done,
  output logic                batch_done_o,
  output logic [31:0]         batch_count_o,
  output logic                desc_err_o
);

  localparam int SLOT_W = $clog2(NUM_DECOMPRESSOR + 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_DECOMPRESSOR);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                close_q, close_d;
  logic                job_valid_q, job_valid_d;
  logic [JOB_ID_W-1:0] job_id_q, job_id_d;
  logic [ADDR_W-1:0]   src_q, src_d, des_q, des_d;
  logic [CLEN_W-1:0]   clen_q, clen_d;
  logic [DLEN_W-1:0]   dlen_q, dlen_d;
  logic                batch_done_q, batch_done_d;
  logic [31:0]         count_q, count_d;
  logic                ready_s;

`ifdef DISPATCH_LEN_CHECK_EN
  logic err_q, err_d;

  function automatic logic len_ok(input logic [CLEN_W-1:0] clen, input logic [DLEN_W-1:0] dlen);
    return (clen != {CLEN_W{1'b0}}) && (dlen != {DLEN_W{1'b0}}) &&
           (clen <= CLEN_W'(MAX_BLOCK_BYTES));
  endfunction
`endif

  // Next-state, slot bookkeeping and output register inputs.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    close_d      = close_q;
    job_valid_d  = 1'b0;
    job_id_d     = job_id_q;
    src_d        = src_q;
    des_d        = des_q;
    clen_d       = clen_q;
    dlen_d       = dlen_q;
    batch_done_d = 1'b0;
    count_d      = count_q;
    ready_s      = 1'b0;
`ifdef DISPATCH_LEN_CHECK_EN
    err_d        = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        slot_d  = {SLOT_W{1'b0}};
        close_d = 1'b0;
        if (io_idle) state_d = ST_LOAD;
        else         state_d = ST_IDLE;
      end
      ST_LOAD: begin
        ready_s = (slot_q < SLOT_MAX) & ~job_valid_q;
        if (desc_valid & ready_s) begin
`ifdef DISPATCH_LEN_CHECK_EN
          if (!len_ok(desc_comp_len, desc_decomp_len)) begin
            // Dropped descriptor still honours desc_last; an empty batch is abandoned.
            err_d = 1'b1;
            if (desc_last) state_d = (slot_q == {SLOT_W{1'b0}}) ? ST_IDLE : ST_START;
            else           state_d = ST_LOAD;
          end else
`endif
          begin
            job_valid_d = 1'b1;
            job_id_d    = JOB_ID_W'(slot_q);
            src_d       = desc_src_addr;
            des_d       = desc_des_addr;
            clen_d      = desc_comp_len;
            dlen_d      = desc_decomp_len;
            slot_d      = slot_q + SLOT_W'(1);
            close_d     = desc_last | ((slot_q + SLOT_W'(1)) == SLOT_MAX);
          end
        end else if (job_valid_q & close_q) begin
          state_d = ST_START;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_START: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!io_idle) state_d = ST_WAIT_DONE;
        else          state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        if (io_idle & io_done) begin
          batch_done_d = 1'b1;
          count_d      = count_q + 32'd1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= {SLOT_W{1'b0}};
      close_q      <= 1'b0;
      job_valid_q  <= 1'b0;
      job_id_q     <= {JOB_ID_W{1'b0}};
      src_q        <= {ADDR_W{1'b0}};
      des_q        <= {ADDR_W{1'b0}};
      clen_q       <= {CLEN_W{1'b0}};
      dlen_q       <= {DLEN_W{1'b0}};
      batch_done_q <= 1'b0;
      count_q      <= 32'd0;
`ifdef DISPATCH_LEN_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      close_q      <= close_d;
      job_valid_q  <= job_valid_d;
      job_id_q     <= job_id_d;
      src_q        <= src_d;
      des_q        <= des_d;
      clen_q       <= clen_d;
      dlen_q       <= dlen_d;
      batch_done_q <= batch_done_d;
      count_q      <= count_d;
`ifdef DISPATCH_LEN_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign desc_ready    = ready_s;
  assign job_valid_o   = job_valid_q;
  assign job_id_o      = job_id_q;
  assign src_addr_o    = src_q;
  assign des_addr_o    = des_q;
  assign comp_len_o    = clen_q;
  assign decomp_len_o  = dlen_q;
  assign start_o       = (state_q == ST_START);
  assign batch_done_o  = batch_done_q;
  assign batch_count_o = count_q;
`ifdef DISPATCH_LEN_CHECK_EN
  assign desc_err_o    = err_q;
`else
  assign desc_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_job_dispatcher.sv
// Self-checking bench for job_dispatcher: a cycle table for the basic batch, then
// randomized batches checked against a transaction-level model, plus corner sequences.
module tb_job_dispatcher;
  import job_dispatcher_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, desc_valid, desc_ready, desc_last;
  logic [63:0]   desc_src_addr, desc_des_addr, src_addr_o, des_addr_o;
  logic [34:0]   desc_comp_len, comp_len_o;
  logic [31:0]   desc_decomp_len, decomp_len_o, batch_count_o;
  logic          job_valid_o, start_o, io_idle, io_done, batch_done_o, desc_err_o;
  logic [15:0]   job_id_o;

  job_dispatcher #(.NUM_DECOMPRESSOR(N)) dut (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src_addr(desc_src_addr), .desc_des_addr(desc_des_addr),
    .desc_comp_len(desc_comp_len), .desc_decomp_len(desc_decomp_len),
    .desc_last(desc_last), .job_valid_o(job_valid_o), .job_id_o(job_id_o),
    .src_addr_o(src_addr_o), .des_addr_o(des_addr_o), .comp_len_o(comp_len_o),
    .decomp_len_o(decomp_len_o), .start_o(start_o), .io_idle(io_idle),
    .io_done(io_done), .batch_done_o(batch_done_o), .batch_count_o(batch_count_o),
    .desc_err_o(desc_err_o)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_count;
  logic        exp_err;

  typedef struct packed {
    logic        dv;
    int          fin;
    logic        dlast, idle, done;
    logic        e_ready, e_jv;
    logic [15:0] e_id;
    logic        e_start, e_bd;
    logic [31:0] e_cnt;
    int          e_f;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(logic dv, int fin, logic idle, logic done, logic e_ready,
                              logic e_jv, logic [15:0] e_id, logic e_start, logic e_bd,
                              logic [31:0] e_cnt, int e_f);
    vec_t v;
    v.dv = dv; v.fin = fin; v.dlast = 1'b0; v.idle = idle; v.done = done;
    v.e_ready = e_ready; v.e_jv = e_jv; v.e_id = e_id; v.e_start = e_start;
    v.e_bd = e_bd; v.e_cnt = e_cnt; v.e_f = e_f;
    return v;
  endfunction

  function automatic logic [63:0] src_of(int k); return 64'hA5A5_0000_0000_1000 + 64'(k); endfunction
  function automatic logic [63:0] des_of(int k); return 64'h5A5A_0000_0000_2000 + 64'(k); endfunction
  function automatic logic [34:0] clen_of(int k); return 35'd100 + 35'(k); endfunction
  function automatic logic [31:0] dlen_of(int k); return 32'd300 + 32'(k); endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic chk_fields(input string tag, input logic [63:0] s, input logic [63:0] d,
                            input logic [34:0] c, input logic [31:0] l);
    chk({tag, "_src"}, src_addr_o, s);
    chk({tag, "_des"}, des_addr_o, d);
    chk({tag, "_clen"}, 64'(comp_len_o), 64'(c));
    chk({tag, "_dlen"}, 64'(decomp_len_o), 64'(l));
  endtask

  task automatic wait_ready(output bit ok);
    int w = 0;
    while (!desc_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = desc_ready;
  endtask

  // One batch of len descriptors; expected ids, fields, start and completion come from the model.
  task automatic run_batch(input int len, input bit use_last, input int gate);
    logic [63:0] s, d;
    logic [34:0] c;
    logic [31:0] l;
    bit          ok, seen;
    int          w;
    for (int i = 0; i < len; i++) begin
      s = {$urandom, $urandom};
      d = {$urandom, $urandom};
      c = 35'($urandom_range(65536, 1));
      l = $urandom | 32'd1;
      desc_src_addr = s; desc_des_addr = d; desc_comp_len = c; desc_decomp_len = l;
      desc_last  = use_last && (i == len - 1);
      desc_valid = 1'b1;
      wait_ready(ok);
      if (!ok) begin
        timeout("accept");
        desc_valid = 1'b0;
        return;
      end
      @(negedge clk);
      chk("job_valid", 64'(job_valid_o), 64'd1);
      chk("job_id", 64'(job_id_o), 64'(i));
      chk_fields("job", s, d, c, l);
      chk("ready_in_jv", 64'(desc_ready), 64'd0);
      if (i < len - 1 && $urandom_range(1, 0) == 1) begin
        desc_valid = 1'b0;
        repeat ($urandom_range(2, 1)) begin
          @(negedge clk);
          chk("no_start_mid", 64'(start_o), 64'd0);
        end
      end
    end
    desc_valid = 1'b0;
    desc_last  = 1'b0;
    seen = 0;
    w = 0;
    while (!seen && w < 5) begin
      @(negedge clk);
      w++;
      if (start_o) seen = 1;
      else chk("jv_once", 64'(job_valid_o), 64'd0);
    end
    if (!seen) begin
      timeout("start");
      return;
    end
    chk("start_not_with_jv", 64'(job_valid_o), 64'd0);
    chk("ready_at_start", 64'(desc_ready), 64'd0);
    @(negedge clk);
    chk("start_one_cycle", 64'(start_o), 64'd0);
    io_idle = 1'b0;
    repeat ($urandom_range(3, 1)) begin
      @(negedge clk);
      chk("ready_busy", 64'(desc_ready), 64'd0);
      chk("no_done_busy", 64'(batch_done_o), 64'd0);
    end
    io_idle = 1'b1;
    io_done = 1'b0;
    repeat (gate) begin
      @(negedge clk);
      chk("done_gated", 64'(batch_done_o), 64'd0);
      chk("ready_gated", 64'(desc_ready), 64'd0);
    end
    io_done = 1'b1;
    seen = 0;
    w = 0;
    while (!seen && w < 4) begin
      @(negedge clk);
      w++;
      if (batch_done_o) seen = 1;
    end
    io_done = 1'b0;
    if (!seen) begin
      timeout("batch_done");
      return;
    end
    exp_count = exp_count + 32'd1;
    chk("batch_count", 64'(batch_count_o), 64'(exp_count));
    @(negedge clk);
    chk("done_pulse", 64'(batch_done_o), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 64'(desc_ready), 64'd0);
    chk({tag, "_jv"}, 64'(job_valid_o), 64'd0);
    chk({tag, "_id"}, 64'(job_id_o), 64'd0);
    chk_fields(tag, 64'd0, 64'd0, 35'd0, 32'd0);
    chk({tag, "_start"}, 64'(start_o), 64'd0);
    chk({tag, "_bd"}, 64'(batch_done_o), 64'd0);
    chk({tag, "_cnt"}, 64'(batch_count_o), 64'd0);
    chk({tag, "_err"}, 64'(desc_err_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n = 1'b0; desc_valid = 1'b0; desc_last = 1'b0; io_idle = 1'b1; io_done = 1'b0;
    desc_src_addr = 64'd0; desc_des_addr = 64'd0; desc_comp_len = 35'd0; desc_decomp_len = 32'd0;
    exp_count = 32'd0;
    exp_err   = 1'b0;

    //        dv  fin idle done rdy jv  id     st  bd  cnt  e_f
    vecs[0]  = mk(1, 0, 1, 0, 0, 0, 16'd0, 0, 0, 32'd0, -1);
    vecs[1]  = mk(1, 0, 1, 0, 1, 0, 16'd0, 0, 0, 32'd0, -1);
    vecs[2]  = mk(1, 1, 1, 0, 0, 1, 16'd0, 0, 0, 32'd0,  0);
    vecs[3]  = mk(1, 1, 1, 0, 1, 0, 16'd0, 0, 0, 32'd0, -1);
    vecs[4]  = mk(0, 0, 1, 0, 0, 1, 16'd1, 0, 0, 32'd0,  1);
    vecs[5]  = mk(0, 0, 1, 0, 0, 0, 16'd1, 1, 0, 32'd0, -1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 16'd1, 0, 0, 32'd0, -1);
    vecs[7]  = mk(0, 0, 1, 0, 0, 0, 16'd1, 0, 0, 32'd0, -1);
    vecs[8]  = mk(0, 0, 1, 1, 0, 0, 16'd1, 0, 0, 32'd0, -1);
    vecs[9]  = mk(0, 0, 1, 0, 0, 0, 16'd1, 0, 1, 32'd1, -1);
    vecs[10] = mk(0, 0, 1, 0, 1, 0, 16'd1, 0, 0, 32'd1, -1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");

    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("v%0d_ready", k), 64'(desc_ready), 64'(vecs[k].e_ready));
      chk($sformatf("v%0d_jv", k), 64'(job_valid_o), 64'(vecs[k].e_jv));
      chk($sformatf("v%0d_id", k), 64'(job_id_o), 64'(vecs[k].e_id));
      chk($sformatf("v%0d_start", k), 64'(start_o), 64'(vecs[k].e_start));
      chk($sformatf("v%0d_bd", k), 64'(batch_done_o), 64'(vecs[k].e_bd));
      chk($sformatf("v%0d_cnt", k), 64'(batch_count_o), 64'(vecs[k].e_cnt));
      if (vecs[k].e_f >= 0)
        chk_fields($sformatf("v%0d", k), src_of(vecs[k].e_f), des_of(vecs[k].e_f),
                   clen_of(vecs[k].e_f), dlen_of(vecs[k].e_f));
      desc_valid      = vecs[k].dv;
      desc_last       = vecs[k].dlast;
      desc_src_addr   = src_of(vecs[k].fin);
      desc_des_addr   = des_of(vecs[k].fin);
      desc_comp_len   = clen_of(vecs[k].fin);
      desc_decomp_len = dlen_of(vecs[k].fin);
      io_idle         = vecs[k].idle;
      io_done         = vecs[k].done;
      @(negedge clk);
    end
    exp_count = 32'd1;

    run_batch(1, 1'b1, 0);
    run_batch(N, 1'b0, 10);
    run_batch(N, 1'b1, 2);
    for (int b = 0; b < 20; b++) begin
      int len;
      bit ul;
      len = $urandom_range(N, 1);
      ul  = (len < N) ? 1'b1 : 1'($urandom_range(1, 0));
      run_batch(len, ul, $urandom_range(3, 0));
    end

    // Reset in the job_valid cycle of the first job discards the batch.
    desc_src_addr = 64'h1234; desc_des_addr = 64'h5678;
    desc_comp_len = 35'd64; desc_decomp_len = 32'd128; desc_last = 1'b0;
    desc_valid = 1'b1;
    wait_ready(ok);
    if (!ok) timeout("reset_accept");
    @(negedge clk);
    chk("pre_reset_jv", 64'(job_valid_o), 64'd1);
    rst_n = 1'b0;
    desc_valid = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    rst_n = 1'b1;
    exp_count = 32'd0;
    run_batch(N, 1'b0, 1);

`ifdef DISPATCH_LEN_CHECK_EN
    desc_comp_len = 35'd0; desc_decomp_len = 32'd5; desc_last = 1'b0;
    desc_valid = 1'b1;
    wait_ready(ok);
    if (!ok) timeout("reject_accept");
    @(negedge clk);
    desc_valid = 1'b0;
    exp_err = 1'b1;
    chk("reject_no_jv", 64'(job_valid_o), 64'd0);
    chk("reject_err", 64'(desc_err_o), 64'(exp_err));
    chk("reject_slot_kept", 64'(desc_ready), 64'd1);
    run_batch(1, 1'b1, 0);
    desc_comp_len = 35'd70000; desc_decomp_len = 32'd5; desc_last = 1'b1;
    desc_valid = 1'b1;
    wait_ready(ok);
    if (!ok) timeout("empty_accept");
    @(negedge clk);
    desc_valid = 1'b0;
    desc_last  = 1'b0;
    chk("empty_no_start", 64'(start_o), 64'd0);
    chk("empty_to_idle", 64'(desc_ready), 64'd0);
    @(negedge clk);
    chk("empty_no_start2", 64'(start_o), 64'd0);
    chk("empty_reload", 64'(desc_ready), 64'd1);
`endif

    chk("desc_err_final", 64'(desc_err_o), 64'(exp_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
